// File: rtl/rv32i_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_hazard_ctrl
// Purpose  : Hazard/sequencing controller for the 5-stage RV32I pipeline.
//            Generates stage stall/flush controls, EX-stage forwarding selects,
//            a sticky data-memory timeout flag and saturating debug counters.
// Revision : 1.0 - initial release
// ============================================================================
module rv32i_hazard_ctrl #(
  parameter int RST_HOLD_CYCLES = 4,
  parameter int MEM_TIMEOUT     = 64,
  parameter int CNT_W           = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [31:0]      ifid_instr_i,
  input  logic             ifid_valid_i,
  input  logic [4:0]       idex_rs1_addr_i,
  input  logic [4:0]       idex_rs2_addr_i,
  input  logic [4:0]       idex_rd_addr_i,
  input  logic             idex_memread_i,
  input  logic             idex_valid_i,
  input  logic [4:0]       exmem_rd_addr_i,
  input  logic             exmem_regwrite_i,
  input  logic [1:0]       exmem_wb_sel_i,
  input  logic             exmem_mem_req_i,
  input  logic             exmem_valid_i,
  input  logic [4:0]       memwb_rd_addr_i,
  input  logic             memwb_regwrite_i,
  input  logic [1:0]       memwb_wb_sel_i,
  input  logic             memwb_valid_i,
  input  logic             bj_taken_i,
  input  logic             dmem_ack_i,
  output logic             stall_if_o,
  output logic             stall_id_o,
  output logic             stall_ex_o,
  output logic             stall_mem_o,
  output logic             flush_if_o,
  output logic             flush_id_o,
  output logic             flush_ex_o,
  output logic             flush_mem_o,
  output logic [2:0]       fw0_sel_o,
  output logic [2:0]       fw1_sel_o,
  output logic             mem_err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam logic [3:0] HOLD_LAST = 4'(RST_HOLD_CYCLES - 1);
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    ST_HOLD     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] hold_cnt;
  logic [7:0] wait_cnt;

  logic [6:0] opcode;
  logic [4:0] src1;
  logic [4:0] src2;
  logic       rs1_used;
  logic       rs2_used;
  logic       load_use;
  logic       mem_block;
  logic       flush_event;
  logic       any_stall;
  logic       unused_instr_bits;

  // Operand select for one EX source; the youngest producer (EX/MEM) wins.
  function automatic logic [2:0] fwd_sel(
    input logic [4:0] rs,
    input logic       ex_hit_en,
    input logic [4:0] ex_rd,
    input logic [1:0] ex_sel,
    input logic       wb_hit_en,
    input logic [4:0] wb_rd,
    input logic [1:0] wb_sel
  );
    logic [2:0] sel;
    sel = 3'd0;
    if (rs != 5'd0) begin
      if (ex_hit_en && ex_rd == rs) begin
        // A load still in MEM has no data yet; the load-use bubble prevents it.
        case (ex_sel)
          2'b00:   sel = 3'd1;
          2'b10:   sel = 3'd4;
          default: sel = 3'd0;
        endcase
      end else if (wb_hit_en && wb_rd == rs) begin
        case (wb_sel)
          2'b00:   sel = 3'd2;
          2'b01:   sel = 3'd3;
          2'b10:   sel = 3'd4;
          default: sel = 3'd0;
        endcase
      end
    end
    return sel;
  endfunction

  assign opcode   = ifid_instr_i[6:0];
  assign src1     = ifid_instr_i[19:15];
  assign src2     = ifid_instr_i[24:20];
  assign rs1_used = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
  assign rs2_used = (opcode == OP_REG || opcode == OP_STORE || opcode == OP_BRANCH);

  // Only the opcode and source fields matter for hazard detection.
  assign unused_instr_bits = ^{ifid_instr_i[31:25], ifid_instr_i[14:7]};

  assign load_use = ifid_valid_i && idex_valid_i && idex_memread_i &&
                    (idex_rd_addr_i != 5'd0) &&
                    ((rs1_used && idex_rd_addr_i == src1) ||
                     (rs2_used && idex_rd_addr_i == src2));

  assign mem_block = exmem_mem_req_i && !dmem_ack_i;

  // Stage control decode: memory wait beats redirect, redirect beats load-use.
  always_comb begin
    stall_if_o  = 1'b0;
    stall_id_o  = 1'b0;
    stall_ex_o  = 1'b0;
    stall_mem_o = 1'b0;
    flush_if_o  = 1'b0;
    flush_id_o  = 1'b0;
    flush_ex_o  = 1'b0;
    flush_mem_o = 1'b0;
    flush_event = 1'b0;
    if (!rst_i || state == ST_HOLD) begin
      flush_if_o  = 1'b1;
      flush_id_o  = 1'b1;
      flush_ex_o  = 1'b1;
      flush_mem_o = 1'b1;
    end else if (state == ST_RUN) begin
      if (mem_block) begin
        stall_if_o  = 1'b1;
        stall_id_o  = 1'b1;
        stall_ex_o  = 1'b1;
        stall_mem_o = 1'b1;
      end else if (bj_taken_i) begin
        flush_if_o  = 1'b1;
        flush_id_o  = 1'b1;
        flush_event = 1'b1;
      end else if (load_use) begin
        stall_if_o  = 1'b1;
        flush_id_o  = 1'b1;
        flush_event = 1'b1;
      end
    end else begin
      // Waiting on data memory: freeze everything until the ack cycle.
      stall_if_o  = !dmem_ack_i;
      stall_id_o  = !dmem_ack_i;
      stall_ex_o  = !dmem_ack_i;
      stall_mem_o = !dmem_ack_i;
    end
  end

  assign any_stall = stall_if_o || stall_id_o || stall_ex_o || stall_mem_o;

  assign fw0_sel_o = rst_i ? fwd_sel(idex_rs1_addr_i,
                                     exmem_valid_i && exmem_regwrite_i, exmem_rd_addr_i, exmem_wb_sel_i,
                                     memwb_valid_i && memwb_regwrite_i, memwb_rd_addr_i, memwb_wb_sel_i)
                           : 3'd0;
  assign fw1_sel_o = rst_i ? fwd_sel(idex_rs2_addr_i,
                                     exmem_valid_i && exmem_regwrite_i, exmem_rd_addr_i, exmem_wb_sel_i,
                                     memwb_valid_i && memwb_regwrite_i, memwb_rd_addr_i, memwb_wb_sel_i)
                           : 3'd0;

  // Sequencing FSM: post-reset hold, normal run, and bounded memory wait.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= ST_HOLD;
      hold_cnt  <= 4'd0;
      wait_cnt  <= 8'd0;
      mem_err_o <= 1'b0;
    end else begin
      case (state)
        ST_HOLD: begin
          if (hold_cnt == HOLD_LAST) state <= ST_RUN;
          else                       hold_cnt <= hold_cnt + 4'd1;
        end
        ST_RUN: begin
          if (mem_block) begin
            state    <= ST_MEM_WAIT;
            wait_cnt <= 8'd1;
          end
        end
        ST_MEM_WAIT: begin
          if (dmem_ack_i) begin
            state <= ST_RUN;
          end else if (wait_cnt == WAIT_LAST) begin
            // Give up on the access and let the pipeline move again.
            mem_err_o <= 1'b1;
            state     <= ST_RUN;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= ST_HOLD;
      endcase
    end
  end

  // Saturating debug counters for stall cycles and redirect/bubble flushes.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (any_stall && stall_cnt_o != {CNT_W{1'b1}})
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      if (flush_event && flush_cnt_o != {CNT_W{1'b1}})
        flush_cnt_o <= flush_cnt_o + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire
